// File: rtl/cas_pkg.sv
// cas_pkg: shared constants for the compare-and-swap sorting network.
//   CAS_SNG_WIDTH  - default lane value width
//   CAS_NUM_INPUTS - default lane count
//   ORD_MAX_FIRST  - order bit value that puts the largest value in lane 0
//   ORD_MIN_FIRST  - order bit value that puts the smallest value in lane 0
package cas_pkg;

  localparam int unsigned CAS_SNG_WIDTH  = 6;
  localparam int unsigned CAS_NUM_INPUTS = 4;

  localparam logic ORD_MAX_FIRST = 1'b0;
  localparam logic ORD_MIN_FIRST = 1'b1;

endpackage

// File: rtl/cas_cell.sv
// cas_cell: combinational compare-and-swap of one lane pair.
// Ports:
//   i_lo, i_hi   - values in the lower and higher lane of the pair
//   i_order      - ORD_MAX_FIRST: larger value to lower lane; ORD_MIN_FIRST: smaller value
//   o_lo, o_hi   - resulting values for the lower and higher lane
module cas_cell
  import cas_pkg::*;
#(
  parameter int unsigned SNG_WIDTH = CAS_SNG_WIDTH
) (
  input  logic [SNG_WIDTH-1:0] i_lo,
  input  logic [SNG_WIDTH-1:0] i_hi,
  input  logic                 i_order,
  output logic [SNG_WIDTH-1:0] o_lo,
  output logic [SNG_WIDTH-1:0] o_hi
);

  logic [SNG_WIDTH:0] w_diff;
  logic               w_borrow;
  logic               w_nonzero;
  logic               w_swap;

  always_comb begin
    // Borrow out of the widened subtraction means lo < hi.
    w_diff    = {1'b0, i_lo} - {1'b0, i_hi};
    w_borrow  = w_diff[SNG_WIDTH];
    w_nonzero = |w_diff[SNG_WIDTH-1:0];
    // Equal values give no borrow and a zero difference, so they never swap.
    if (i_order == ORD_MAX_FIRST) begin
      w_swap = w_borrow;
    end else begin
      w_swap = !w_borrow && w_nonzero;
    end
    o_lo = w_swap ? i_hi : i_lo;
    o_hi = w_swap ? i_lo : i_hi;
  end

endmodule

// File: rtl/cas_sort_net.sv
// cas_sort_net: pipelined odd-even transposition sorter, one registered stage per lane.
// Ports:
//   clk, rst_n           - clock and asynchronous active-low reset
//   in_valid / in_ready  - input handshake; in_ready is the global advance
//   in_data, in_order    - packed lanes (lane k at [k*SNG_WIDTH +: SNG_WIDTH]) and order bit
//   out_valid / out_ready- output handshake
//   out_data, out_order  - sorted vector and the order bit that travelled with it
//   occupancy            - number of valid vectors held in the pipeline
module cas_sort_net
  import cas_pkg::*;
#(
  parameter int unsigned SNG_WIDTH  = CAS_SNG_WIDTH,
  parameter int unsigned NUM_INPUTS = CAS_NUM_INPUTS
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0]     in_data,
  input  logic                                in_order,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_INPUTS*SNG_WIDTH-1:0]     out_data,
  output logic                                out_order,
  output logic [$clog2(NUM_INPUTS+1)-1:0]     occupancy
);

  localparam int unsigned VecW = NUM_INPUTS * SNG_WIDTH;
  localparam int unsigned OccW = $clog2(NUM_INPUTS + 1);

  logic [NUM_INPUTS-1:0][VecW-1:0] r_data;
  logic [NUM_INPUTS-1:0]           r_order;
  logic [NUM_INPUTS-1:0]           r_valid;
  logic [OccW-1:0]                 r_occ;

  logic [NUM_INPUTS-1:0][VecW-1:0] w_stage_in;
  logic [NUM_INPUTS-1:0][VecW-1:0] w_stage_out;
  logic [NUM_INPUTS-1:0]           w_stage_ord;
  logic [OccW-1:0]                 w_occ_next;
  logic                            w_adv;
  logic                            w_accept;
  logic                            w_emit;

  assign w_adv    = !r_valid[NUM_INPUTS-1] || out_ready;
  assign w_accept = in_valid && w_adv;
  assign w_emit   = r_valid[NUM_INPUTS-1] && out_ready;

  // Stage s compares the vector entering it, then registers the result into r_data[s].
  for (genvar s = 0; s < NUM_INPUTS; s++) begin : g_stage
    localparam int Par = s % 2;

    if (s == 0) begin : g_first
      // Bubbles enter as zeros so idle input lanes never reach the state.
      assign w_stage_in[s]  = in_valid ? in_data : '0;
      assign w_stage_ord[s] = in_valid & in_order;
    end else begin : g_next
      assign w_stage_in[s]  = r_data[s-1];
      assign w_stage_ord[s] = r_order[s-1];
    end

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_lane
      localparam bit IsLower = (k >= Par) && (((k - Par) % 2) == 0) && (k + 1 < NUM_INPUTS);
      localparam bit IsUpper = (k >= Par + 1) && (((k - Par) % 2) == 1);

      if (IsLower) begin : g_cell
        cas_cell #(
          .SNG_WIDTH (SNG_WIDTH)
        ) u_cas_cell (
          .i_lo    (w_stage_in[s][k*SNG_WIDTH +: SNG_WIDTH]),
          .i_hi    (w_stage_in[s][(k+1)*SNG_WIDTH +: SNG_WIDTH]),
          .i_order (w_stage_ord[s]),
          .o_lo    (w_stage_out[s][k*SNG_WIDTH +: SNG_WIDTH]),
          .o_hi    (w_stage_out[s][(k+1)*SNG_WIDTH +: SNG_WIDTH])
        );
      end else if (!IsUpper) begin : g_pass
        // Lane without a partner in this stage.
        assign w_stage_out[s][k*SNG_WIDTH +: SNG_WIDTH] =
            w_stage_in[s][k*SNG_WIDTH +: SNG_WIDTH];
      end
    end
  end

  always_comb begin
    w_occ_next = r_occ;
    if (w_accept && !w_emit) begin
      w_occ_next = r_occ + 1'b1;
    end else if (!w_accept && w_emit) begin
      w_occ_next = r_occ - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_order <= '0;
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      // All stages move together; empty stages travel as bubbles.
      if (w_adv) begin
        r_data  <= w_stage_out;
        r_order <= w_stage_ord;
        r_valid <= {r_valid[NUM_INPUTS-2:0], in_valid};
      end
      r_occ <= w_occ_next;
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_valid[NUM_INPUTS-1];
  assign out_data  = r_data[NUM_INPUTS-1];
  assign out_order = r_order[NUM_INPUTS-1];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_cas_sort_net.sv
// tb_cas_sort_net: directed and randomized checks of cas_sort_net against a
// stage-slot reference model whose slots hold already-sorted vectors.
module tb_cas_sort_net;
  import cas_pkg::*;

  localparam int N  = 4;
  localparam int W  = 6;
  localparam int VW = N * W;
  localparam int OW = $clog2(N + 1);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          in_order;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic          out_order;
  logic [OW-1:0] occupancy;

  int n_checks;
  int n_fail;

  logic          m_vld [N];
  logic [VW-1:0] m_dat [N];
  logic          m_ord [N];
  int            m_occ;

  logic          acc;
  logic [VW-1:0] vq [8];
  logic          oq [8];
  int            idx;
  int            guard;
  int            n_acc;
  int            ncyc;
  logic          pend;
  logic [VW-1:0] pd;
  logic          po;
  logic [VW-1:0] v1;

  cas_sort_net #(
    .SNG_WIDTH  (W),
    .NUM_INPUTS (N)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_order  (in_order),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_order (out_order),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  // Plain sort of the lanes; lane 0 gets the smallest or the largest value.
  function automatic logic [VW-1:0] ref_sort(input logic [VW-1:0] d, input logic ord);
    int v [N];
    int t;
    logic [VW-1:0] r;
    for (int k = 0; k < N; k++) v[k] = int'(d[k*W +: W]);
    for (int i = 1; i < N; i++) begin
      for (int j = i; j > 0; j--) begin
        if (v[j-1] > v[j]) begin
          t = v[j-1]; v[j-1] = v[j]; v[j] = t;
        end
      end
    end
    r = '0;
    for (int k = 0; k < N; k++) begin
      r[k*W +: W] = W'((ord == ORD_MIN_FIRST) ? v[k] : v[N-1-k]);
    end
    return r;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < N; k++) begin
      m_vld[k] = 1'b0;
      m_dat[k] = '0;
      m_ord[k] = 1'b0;
    end
    m_occ = 0;
  endfunction

  task automatic check_outputs();
    check_eq("out_valid", 64'(out_valid), 64'(m_vld[N-1]));
    if (m_vld[N-1]) begin
      check_eq("out_data", 64'(out_data), 64'(m_dat[N-1]));
      check_eq("out_order", 64'(out_order), 64'(m_ord[N-1]));
    end
    check_eq("occupancy", 64'(occupancy), 64'(m_occ));
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model, check at next negedge.
  task automatic cyc(input logic iv, input logic [VW-1:0] d, input logic ord,
                     input logic ordy, output logic a);
    logic adv;
    logic emit;
    in_valid  = iv;
    in_data   = d;
    in_order  = ord;
    out_ready = ordy;
    adv  = !m_vld[N-1] || ordy;
    a    = iv && adv;
    emit = m_vld[N-1] && ordy;
    #1;
    check_eq("in_ready", 64'(in_ready), 64'(adv));
    if (adv) begin
      for (int s = N - 1; s > 0; s--) begin
        m_vld[s] = m_vld[s-1];
        m_dat[s] = m_dat[s-1];
        m_ord[s] = m_ord[s-1];
      end
      m_vld[0] = iv;
      m_dat[0] = iv ? ref_sort(d, ord) : '0;
      m_ord[0] = iv & ord;
    end
    if (a && !emit) m_occ++;
    else if (!a && emit) m_occ--;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    logic a;
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b1, a);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_order  = 1'b0;
    out_ready = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_occupancy", 64'(occupancy), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("post_rst_out_data", 64'(out_data), 64'(0));
    check_eq("post_rst_out_order", 64'(out_order), 64'(0));
    check_eq("post_rst_occupancy", 64'(occupancy), 64'(0));
    check_eq("post_rst_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_order  = 1'b0;
    out_ready = 1'b1;
    model_clear();
    #2;
    apply_reset();

    // Known vector, max-first then min-first directly behind it.
    v1 = pack4(3, 63, 0, 17);
    cyc(1'b1, v1, ORD_MAX_FIRST, 1'b1, acc);
    cyc(1'b1, v1, ORD_MIN_FIRST, 1'b1, acc);
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    check_eq("lat_not_early", 64'(out_valid), 64'(0));
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    check_eq("lat_valid", 64'(out_valid), 64'(1));
    check_eq("max_first_data", 64'(out_data), 64'(pack4(63, 17, 3, 0)));
    check_eq("max_first_order", 64'(out_order), 64'(ORD_MAX_FIRST));
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    check_eq("min_first_valid", 64'(out_valid), 64'(1));
    check_eq("min_first_data", 64'(out_data), 64'(pack4(0, 3, 17, 63)));
    check_eq("min_first_order", 64'(out_order), 64'(ORD_MIN_FIRST));
    idle(4);

    // Back-pressure: five vectors offered with out_ready low.
    for (int i = 0; i < 8; i++) begin
      vq[i] = VW'($urandom);
      oq[i] = 1'($urandom);
    end
    idx = 0;
    repeat (6) begin
      cyc(1'b1, vq[idx], oq[idx], 1'b0, acc);
      if (acc) idx++;
    end
    check_eq("stall_occupancy", 64'(occupancy), 64'(4));
    check_eq("stall_in_ready", 64'(in_ready), 64'(0));
    check_eq("stall_out_valid", 64'(out_valid), 64'(1));
    check_eq("stall_out_data", 64'(out_data), 64'(ref_sort(vq[0], oq[0])));
    repeat (2) begin
      cyc(1'b1, vq[idx], oq[idx], 1'b0, acc);
      if (acc) idx++;
    end
    check_eq("stall_stable", 64'(out_data), 64'(ref_sort(vq[0], oq[0])));
    guard = 0;
    while (idx < 5 && guard < 20) begin
      cyc(1'b1, vq[idx], oq[idx], 1'b1, acc);
      if (acc) idx++;
      guard++;
    end
    idle(6);

    // Duplicate-heavy vectors.
    cyc(1'b1, pack4(5, 5, 5, 5), ORD_MAX_FIRST, 1'b1, acc);
    cyc(1'b1, pack4(42, 7, 42, 7), ORD_MAX_FIRST, 1'b1, acc);
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    check_eq("equal_data", 64'(out_data), 64'(pack4(5, 5, 5, 5)));
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    check_eq("dup_data", 64'(out_data), 64'(pack4(42, 42, 7, 7)));
    idle(3);

    // Reset in the middle of traffic with three vectors in flight.
    repeat (3) cyc(1'b1, VW'($urandom), 1'($urandom), 1'b1, acc);
    check_eq("midrst_occ_before", 64'(occupancy), 64'(3));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
    check_eq("midrst_occupancy", 64'(occupancy), 64'(0));
    check_eq("midrst_out_data", 64'(out_data), 64'(0));
    check_eq("midrst_out_order", 64'(out_order), 64'(0));
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(8);

    // Random traffic; an offered vector stays offered until accepted.
    n_acc = 0;
    ncyc  = 0;
    pend  = 1'b0;
    pd    = '0;
    po    = 1'b0;
    while (n_acc < 10000 && ncyc < 60000) begin
      if (!pend && ($urandom_range(0, 9) < 7)) begin
        pend = 1'b1;
        po   = 1'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          for (int k = 0; k < N; k++) pd[k*W +: W] = W'($urandom_range(0, 3));
        end else begin
          pd = VW'($urandom);
        end
      end
      cyc(pend, pend ? pd : VW'($urandom), pend ? po : 1'($urandom),
          1'($urandom_range(0, 9) < 7), acc);
      if (acc) begin
        pend = 1'b0;
        n_acc++;
      end
      ncyc++;
    end
    check_eq("random_accepted", 64'(n_acc), 64'(10000));
    idle(N + 2);
    check_eq("final_occupancy", 64'(occupancy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
